trap_ctrl: RTL

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/trap_ctrl.sv
// trap_ctrl: sequences exception/interrupt entry and MRET/SRET return into
// one-cycle CSR strobes followed by a single fetch redirect.
module trap_ctrl #(
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid,
  input  logic [4:0]  exc_cause,
  input  logic [31:0] exc_tval,
  input  logic [31:0] cmt_pc,
  input  logic        mret_req,
  input  logic        sret_req,
  input  logic [31:0] next_pc,
  input  logic        next_pc_valid,
  input  logic        timer_irq,
  input  logic        mie_mtie,
  input  logic        mstatus_mie,
  input  logic [1:0]  priv_mode,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic [31:0] sepc,
  output logic        trap_enter,
  output logic [31:0] trap_cause,
  output logic [31:0] trap_pc,
  output logic [31:0] trap_val,
  output logic        mret_exec,
  output logic        sret_exec,
  output logic        flush,
  output logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);
  typedef enum logic [1:0] {IDLE, ENTER, RET, REDIRECT} state_t;
  state_t state_q, state_d;
  logic [31:0] cause_q, cause_d, pc_q, pc_d, val_q, val_d, tgt_q, tgt_d;
  logic is_m_q, is_m_d;
  logic enter_q, enter_d, mret_q, mret_d, sret_q, sret_d, busy_q, busy_d, rv_q, rv_d;
  logic irq, ill, vec;
  assign irq = timer_irq & mie_mtie & (mstatus_mie | (priv_mode != 2'd3)) & next_pc_valid;
  assign ill = (mret_req & (priv_mode != 2'd3)) | (sret_req & (priv_mode == 2'd0));
  assign vec = VECTORED_EN && (mtvec[1:0] == 2'b01) && cause_q[31];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cause_q <= '0;
      pc_q    <= '0;
      val_q   <= '0;
      tgt_q   <= '0;
      is_m_q  <= 1'b0;
      enter_q <= 1'b0;
      mret_q  <= 1'b0;
      sret_q  <= 1'b0;
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      pc_q    <= pc_d;
      val_q   <= val_d;
      tgt_q   <= tgt_d;
      is_m_q  <= is_m_d;
      enter_q <= enter_d;
      mret_q  <= mret_d;
      sret_q  <= sret_d;
      busy_q  <= busy_d;
      rv_q    <= rv_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    pc_d    = pc_q;
    val_d   = val_q;
    tgt_d   = tgt_q;
    is_m_d  = is_m_q;
    case (state_q)
      IDLE: begin
        if (exc_valid) begin
          state_d = ENTER;
          cause_d = {27'b0, exc_cause};
          pc_d    = cmt_pc;
          val_d   = exc_tval;
        end else if (ill) begin
          state_d = ENTER;
          cause_d = 32'd2;
          pc_d    = cmt_pc;
          val_d   = '0;
        end else if (irq) begin
          state_d = ENTER;
          cause_d = 32'h8000_0007;
          pc_d    = next_pc;
          val_d   = '0;
        end else if (mret_req | sret_req) begin
          state_d = RET;
          is_m_d  = mret_req;
          tgt_d   = mret_req ? mepc : sepc;
        end
      end
      ENTER: begin
        state_d = REDIRECT;
        tgt_d   = {mtvec[31:2], 2'b00} + (vec ? {25'b0, cause_q[4:0], 2'b00} : 32'd0);
      end
      RET:     state_d = REDIRECT;
      default: state_d = IDLE;
    endcase
  end
  // Strobes are decoded from the next state so every output comes straight from a flop.
  always_comb begin
    enter_d = state_d == ENTER;
    mret_d  = (state_d == RET) & is_m_d;
    sret_d  = (state_d == RET) & ~is_m_d;
    busy_d  = state_d != IDLE;
    rv_d    = state_d == REDIRECT;
  end
  assign trap_enter     = enter_q;
  assign trap_cause     = cause_q;
  assign trap_pc        = pc_q;
  assign trap_val       = val_q;
  assign mret_exec      = mret_q;
  assign sret_exec      = sret_q;
  assign flush          = busy_q;
  assign stall          = busy_q;
  assign redirect_valid = rv_q;
  assign redirect_pc    = tgt_q;
endmodule
